// File: rtl/vanilla_remote_req_arbiter.sv
// ---------------------------------------------------------------------------
// vanilla_remote_req_arbiter
//
// Shares the vanilla core's single outgoing remote-request channel between
// the icache miss fetcher and the load/store unit. The block owns the
// endpoint credit counter for that channel. It grants a request only while a
// credit is available, and it breaks ties round-robin. The granted request
// is registered and presented on a valid-only interface. That interface
// feeds the EVA->NPA translation and the packet builder, and it has no
// backpressure. The block also reports fence status, meaning that no
// request is outstanding.
//
// Ports
//   clk_i               in   1                clock
//   reset_i             in   1                synchronous active-high reset
//   ifetch_req_i        in   req_width_p      icache miss request
//   ifetch_v_i          in   1                ifetch request valid
//   ifetch_yumi_o       out  1                ifetch request granted this cycle
//   lsu_req_i           in   req_width_p      load/store/amo request
//   lsu_v_i             in   1                lsu request valid
//   lsu_yumi_o          out  1                lsu request granted this cycle
//   remote_req_o        out  req_width_p      registered granted request
//   remote_req_v_o      out  1                one-cycle valid pulse per grant
//   remote_req_credit_i in   1                one credit returned by endpoint
//   credits_o           out  credit_width_lp  credits currently available
//   fence_done_o        out  1                all credits home, output idle
// ---------------------------------------------------------------------------
module vanilla_remote_req_arbiter #(
   parameter  int req_width_p       = 128,
   parameter  int max_out_credits_p = 32,
   localparam int credit_width_lp   = $clog2(max_out_credits_p + 1)
) (
   input  logic                       clk_i,
   input  logic                       reset_i,
   input  logic [req_width_p-1:0]     ifetch_req_i,
   input  logic                       ifetch_v_i,
   output logic                       ifetch_yumi_o,
   input  logic [req_width_p-1:0]     lsu_req_i,
   input  logic                       lsu_v_i,
   output logic                       lsu_yumi_o,
   output logic [req_width_p-1:0]     remote_req_o,
   output logic                       remote_req_v_o,
   input  logic                       remote_req_credit_i,
   output logic [credit_width_lp-1:0] credits_o,
   output logic                       fence_done_o
);

   // Identity of the most recent winner. It selects who loses the next tie.
   typedef enum logic {
      grant_ifetch_e = 1'b0,
      grant_lsu_e    = 1'b1
   } grant_e;

   localparam logic [credit_width_lp-1:0] max_credits_lp = credit_width_lp'(max_out_credits_p);
   localparam logic [credit_width_lp-1:0] one_credit_lp  = credit_width_lp'(1);
   localparam logic [credit_width_lp-1:0] zero_credit_lp = credit_width_lp'(0);

   grant_e                     last_grant_r;
   grant_e                     last_grant_n_s;
   logic [credit_width_lp-1:0] credits_r;
   logic [credit_width_lp-1:0] credits_n_s;
   logic [req_width_p-1:0]     req_r;
   logic [req_width_p-1:0]     req_n_s;
   logic                       req_v_r;
   logic                       req_v_n_s;
   logic                       can_send_s;
   logic                       ifetch_yumi_s;
   logic                       lsu_yumi_s;
   logic                       grant_s;

   // Grant decision: credit-gated, round-robin on a tie, suppressed in reset.
   // A credit returned in this cycle deliberately plays no part here, which
   // keeps the yumi path free of the credit-return input.
   always_comb begin
      can_send_s    = (credits_r != zero_credit_lp);
      ifetch_yumi_s = 1'b0;
      lsu_yumi_s    = 1'b0;
      if (reset_i || !can_send_s) begin
         ifetch_yumi_s = 1'b0;
         lsu_yumi_s    = 1'b0;
      end else if (ifetch_v_i && lsu_v_i) begin
         if (last_grant_r == grant_lsu_e) begin
            ifetch_yumi_s = 1'b1;
         end else begin
            lsu_yumi_s = 1'b1;
         end
      end else if (ifetch_v_i) begin
         ifetch_yumi_s = 1'b1;
      end else if (lsu_v_i) begin
         lsu_yumi_s = 1'b1;
      end else begin
         ifetch_yumi_s = 1'b0;
         lsu_yumi_s    = 1'b0;
      end
      grant_s = ifetch_yumi_s | lsu_yumi_s;
   end

   // Next-state for the output register and the round-robin pointer.
   always_comb begin
      last_grant_n_s = last_grant_r;
      req_n_s        = req_r;
      req_v_n_s      = grant_s;
      if (ifetch_yumi_s) begin
         last_grant_n_s = grant_ifetch_e;
         req_n_s        = ifetch_req_i;
      end else if (lsu_yumi_s) begin
         last_grant_n_s = grant_lsu_e;
         req_n_s        = lsu_req_i;
      end else begin
         last_grant_n_s = last_grant_r;
         req_n_s        = req_r;
      end
   end

   // Credit counter next-state. A grant and a return in the same cycle
   // cancel out. A return while already full is a protocol error, and the
   // counter saturates instead of wrapping.
   always_comb begin
      credits_n_s = credits_r;
      case ({grant_s, remote_req_credit_i})
         2'b10:   credits_n_s = credits_r - one_credit_lp;
         2'b01: begin
            if (credits_r == max_credits_lp) begin
               credits_n_s = credits_r;
            end else begin
               credits_n_s = credits_r + one_credit_lp;
            end
         end
         default: credits_n_s = credits_r;
      endcase
   end

   // State registers. Reset drops any pending output without sending it and
   // points the round-robin at the LSU, so ifetch wins the first tie.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         last_grant_r <= grant_lsu_e;
         credits_r    <= max_credits_lp;
         req_r        <= {req_width_p{1'b0}};
         req_v_r      <= 1'b0;
      end else begin
         last_grant_r <= last_grant_n_s;
         credits_r    <= credits_n_s;
         req_r        <= req_n_s;
         req_v_r      <= req_v_n_s;
      end
   end

   assign ifetch_yumi_o  = ifetch_yumi_s;
   assign lsu_yumi_o     = lsu_yumi_s;
   assign remote_req_o   = req_r;
   assign remote_req_v_o = req_v_r;
   assign credits_o      = credits_r;
   // Fence completes when every credit is home and nothing sits in the
   // output register waiting to leave.
   assign fence_done_o   = (credits_r == max_credits_lp) && !req_v_r;

   vanilla_remote_req_arbiter_chk #(
      .credit_width_lp  (credit_width_lp),
      .max_out_credits_p(max_out_credits_p)
   ) chk (
      .clk          (clk_i),
      .reset        (reset_i),
      .ifetch_yumi  (ifetch_yumi_s),
      .lsu_yumi     (lsu_yumi_s),
      .credits      (credits_r),
      .credit_return(remote_req_credit_i)
   );

endmodule

// ---------------------------------------------------------------------------
// vanilla_remote_req_arbiter_chk
//
// Protocol checker for the arbiter. It contains no logic that synthesis
// keeps.
//
// Ports
//   clk, reset     in  clock and synchronous reset of the arbiter
//   ifetch_yumi    in  ifetch grant
//   lsu_yumi       in  lsu grant
//   credits        in  current credit count
//   credit_return  in  credit returned by the endpoint
// ---------------------------------------------------------------------------
module vanilla_remote_req_arbiter_chk #(
   parameter int credit_width_lp   = 6,
   parameter int max_out_credits_p = 32
) (
   input logic                       clk,
   input logic                       reset,
   input logic                       ifetch_yumi,
   input logic                       lsu_yumi,
   input logic [credit_width_lp-1:0] credits,
   input logic                       credit_return
);

   localparam logic [credit_width_lp-1:0] max_credits_lp = credit_width_lp'(max_out_credits_p);

   a_one_grant: assert property (@(posedge clk) disable iff (reset)
      !(ifetch_yumi && lsu_yumi))
      else $error("arbiter: both yumis high");

   a_no_credit_no_grant: assert property (@(posedge clk) disable iff (reset)
      (credits == {credit_width_lp{1'b0}}) |-> !(ifetch_yumi || lsu_yumi))
      else $error("arbiter: grant with zero credits");

   a_credit_overflow: assert property (@(posedge clk) disable iff (reset)
      !(credit_return && (credits == max_credits_lp) && !(ifetch_yumi || lsu_yumi)))
      else $error("arbiter: credit returned while counter full");

endmodule
